// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/dmem_store.sv
// Word-addressed storage: synchronous write, combinational read.
// Contents are deliberately not reset so data survives a core reset.
module dmem_store
  import dmem_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] w_data,
  output logic [WORD_W-1:0] r_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Commit a write at the clock edge when enabled.
  always_ff @(posedge clk_i) begin
    if (we) mem[idx] <= w_data;
  end

  // Read is combinational so the responder can register it at the final BUSY edge.
  always_comb r_data = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle responder for the CPU data-memory port. Holds the pipeline
// with stall_o for LATENCY+1 cycles, then pulses ack_o for one cycle.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting; stall_o follows the live request combinationally
//   BUSY  | access in flight; counter runs down from LATENCY-1 to 0
//   DONE  | ack_o/err_o/r_data_o valid; live request inputs are ignored
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int LATENCY = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [31:0]       addr_i,
  input  logic [WORD_W-1:0] w_data_i,
  output logic [WORD_W-1:0] r_data_o,
  output logic              stall_o,
  output logic              ack_o,
  output logic              err_o
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            state;
  logic [3:0]        cnt;
  op_t               op_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic              mis_q;
  logic [WORD_W-1:0] rd_word;
  logic              req;
  logic              last_busy;
  logic              store_we;
  logic              unused_addr;

  assign req         = MemRead_i | MemWrite_i;
  assign last_busy   = (state == BUSY) && (cnt == 4'd0);
  assign unused_addr = ^addr_i[31:AW+2];

  // A reset landing on the final BUSY edge must still suppress the commit.
  assign store_we = last_busy && (op_q == OP_WR) && !mis_q && !rst_i;

  // Stall is combinational in IDLE so the request cycle itself is held.
  always_comb begin
    stall_o = 1'b0;
    case (state)
      IDLE:    stall_o = req;
      BUSY:    stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
  end

  // Sequencing FSM with latency counter, request capture and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      op_q     <= OP_RD;
      idx_q    <= '0;
      wdata_q  <= '0;
      mis_q    <= 1'b0;
      r_data_o <= '0;
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            op_q    <= MemWrite_i ? OP_WR : OP_RD;
            idx_q   <= addr_i[AW+1:2];
            wdata_q <= w_data_i;
            mis_q   <= (addr_i[1:0] != 2'b00);
            cnt     <= CNT_INIT;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (op_q == OP_RD && !mis_q) r_data_o <= rd_word;
            ack_o <= 1'b1;
            err_o <= mis_q;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  dmem_store #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .clk_i  (clk_i),
    .we     (store_we),
    .idx    (idx_q),
    .w_data (wdata_q),
    .r_data (rd_word)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed, table-driven bench for data_mem_responder. One instance uses
// LATENCY=3 for the vector table and reset-abort case; a second uses
// LATENCY=1 for the back-to-back sequence.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;

  logic        mem_read, mem_write;
  logic [31:0] addr, w_data, r_data;
  logic        stall, ack, err;

  logic        b_read, b_write;
  logic [31:0] b_addr, b_w_data, b_r_data;
  logic        b_stall, b_ack, b_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(32), .AW(5), .LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .MemRead_i(mem_read), .MemWrite_i(mem_write),
    .addr_i(addr), .w_data_i(w_data),
    .r_data_o(r_data), .stall_o(stall), .ack_o(ack), .err_o(err)
  );

  data_mem_responder #(.DEPTH(32), .AW(5), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .MemRead_i(b_read), .MemWrite_i(b_write),
    .addr_i(b_addr), .w_data_i(b_w_data),
    .r_data_o(b_r_data), .stall_o(b_stall), .ack_o(b_ack), .err_o(b_err)
  );

  // Protocol watch: a request must not newly appear while an access is in flight.
  logic req3_prev = 1'b0, stall3_prev = 1'b0;
  logic req1_prev = 1'b0, stall1_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      assert (!((mem_read | mem_write) && !req3_prev && (ack || stall3_prev)))
        else $error("protocol violation on LATENCY=3 instance");
      assert (!((b_read | b_write) && !req1_prev && (b_ack || stall1_prev)))
        else $error("protocol violation on LATENCY=1 instance");
    end
    req3_prev   <= mem_read | mem_write;
    stall3_prev <= stall;
    req1_prev   <= b_read | b_write;
    stall1_prev <= b_stall;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  // Issue one held request on the LATENCY=3 instance and check its completion.
  // Entered and left at 1 time unit after a rising edge in an idle cycle.
  task automatic do_access(input vec_t v, input int n);
    int stalls = 0;
    int guard  = 0;
    mem_read  = v.rd;
    mem_write = v.wr;
    addr      = v.a;
    w_data    = v.wd;
    #1;
    while (stall && guard < 40) begin
      stalls++;
      guard++;
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d stall_cycles", n), 32'(stalls), 32'd4);
    chk($sformatf("v%0d ack", n), {31'd0, ack}, 32'd1);
    chk($sformatf("v%0d err", n), {31'd0, err}, {31'd0, v.exp_err});
    chk($sformatf("v%0d r_data", n), r_data, v.exp_rdata);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d ack_drop", n), {30'd0, ack, stall}, 32'd0);
  endtask

  vec_t vecs [10];

  initial begin
    int stalls, guard, ack_seen;

    vecs[0] = '{rd:0, wr:1, a:32'h0000_0010, wd:32'hDEAD_BEEF, exp_rdata:32'h0,          exp_err:0};
    vecs[1] = '{rd:1, wr:0, a:32'h0000_0010, wd:32'h0,         exp_rdata:32'hDEAD_BEEF, exp_err:0};
    vecs[2] = '{rd:1, wr:0, a:32'h0000_0090, wd:32'h0,         exp_rdata:32'hDEAD_BEEF, exp_err:0};
    vecs[3] = '{rd:1, wr:0, a:32'h0000_0013, wd:32'h0,         exp_rdata:32'hDEAD_BEEF, exp_err:1};
    vecs[4] = '{rd:1, wr:0, a:32'h0000_0010, wd:32'h0,         exp_rdata:32'hDEAD_BEEF, exp_err:0};
    vecs[5] = '{rd:1, wr:1, a:32'h0000_0008, wd:32'h0000_1234, exp_rdata:32'hDEAD_BEEF, exp_err:0};
    vecs[6] = '{rd:1, wr:0, a:32'h0000_0008, wd:32'h0,         exp_rdata:32'h0000_1234, exp_err:0};
    vecs[7] = '{rd:0, wr:1, a:32'h0000_0020, wd:32'h1111_1111, exp_rdata:32'h0000_1234, exp_err:0};
    vecs[8] = '{rd:0, wr:1, a:32'h0000_0022, wd:32'h0000_0099, exp_rdata:32'h0000_1234, exp_err:1};
    vecs[9] = '{rd:1, wr:0, a:32'h0000_0020, wd:32'h0,         exp_rdata:32'h1111_1111, exp_err:0};

    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; addr = '0; w_data = '0;
    b_read = 1'b0; b_write = 1'b0; b_addr = '0; b_w_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset stall/ack/err", {29'd0, stall, ack, err}, 32'd0);
    chk("reset r_data", r_data, 32'd0);
    chk("reset b_r_data", b_r_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) do_access(vecs[i], i);

    // Reset in the second BUSY cycle aborts a write to word 8.
    mem_write = 1'b1; addr = 32'h0000_0020; w_data = 32'h0000_CAFE;
    #1;
    ack_seen = 0;
    @(posedge clk); #1;
    if (ack) ack_seen++;
    @(posedge clk); #1;
    if (ack) ack_seen++;
    rst = 1'b1;
    mem_write = 1'b0;
    @(posedge clk); #1;
    chk("abort outputs", {29'd0, stall, ack, err}, 32'd0);
    chk("abort r_data", r_data, 32'd0);
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack) ack_seen++;
    end
    chk("abort no ack", 32'(ack_seen), 32'd0);
    do_access('{rd:1, wr:0, a:32'h0000_0020, wd:32'h0, exp_rdata:32'h1111_1111, exp_err:0}, 10);

    // Back-to-back held requests on the LATENCY=1 instance.
    b_write = 1'b1; b_addr = 32'h0000_0004; b_w_data = 32'h0000_0005;
    #1;
    stalls = 0; guard = 0;
    while (b_stall && guard < 40) begin
      stalls++; guard++;
      @(posedge clk); #1;
    end
    chk("b2b wr stalls", 32'(stalls), 32'd2);
    chk("b2b wr ack", {31'd0, b_ack}, 32'd1);
    b_write = 1'b0; b_read = 1'b1;
    @(posedge clk); #1;
    stalls = 0; guard = 0;
    while (b_stall && guard < 40) begin
      stalls++; guard++;
      @(posedge clk); #1;
    end
    chk("b2b rd stalls", 32'(stalls), 32'd2);
    chk("b2b rd ack", {31'd0, b_ack}, 32'd1);
    chk("b2b rd data", b_r_data, 32'h0000_0005);
    b_read = 1'b0;
    @(posedge clk); #1;
    chk("b2b idle", {30'd0, b_ack, b_stall}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
